// File: rtl/uart_rx_deframer_if.sv
// Stream bundle for the UART receiver: configuration input stream and character output stream.
interface uart_rx_deframer_if;
  logic [23:0] s_axis_config_tdata;
  logic        s_axis_config_tvalid;
  logic        s_axis_config_tready;
  logic [15:0] m_axis_tdata;
  logic [2:0]  m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  modport master (
    input  s_axis_config_tdata, s_axis_config_tvalid, m_axis_tready,
    output s_axis_config_tready, m_axis_tdata, m_axis_tuser, m_axis_tvalid
  );

  modport slave (
    output s_axis_config_tdata, s_axis_config_tvalid, m_axis_tready,
    input  s_axis_config_tready, m_axis_tdata, m_axis_tuser, m_axis_tvalid
  );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receiver: synchronises rxd, samples mid-bit, checks parity/stop and delivers
// each character with error flags through a one-deep AXI-Stream output register.
module uart_rx_deframer #(
  parameter int unsigned BAUD_PRESCALER = 12,
  parameter int unsigned PARITY         = 0,
  parameter int unsigned BYTE_SIZE      = 8,
  parameter int unsigned STOP_BITS      = 0
) (
  input  logic               aclk,
  input  logic               aresetn,
  uart_rx_deframer_if.master axis,
  input  logic               rxd,
  output logic               rtsn
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e      state_q, state_d;
  logic        meta_q, meta_d, rxs_q, rxs_d, rxs_prev_q, rxs_prev_d;
  logic [1:0]  real_q, real_d;
  logic        armed_q, armed_d;
  logic [15:0] presc_q, presc_d;
  logic [2:0]  par_mode_q, par_mode_d;
  logic [3:0]  size_q, size_d;
  logic        stop2_q, stop2_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shreg_q, shreg_d;
  logic        run_par_q, run_par_d, par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic        stop_idx_q, stop_idx_d, commit_q, commit_d;
  logic [15:0] tdata_q, tdata_d;
  logic [2:0]  tuser_q, tuser_d;
  logic        tvalid_q, tvalid_d, overrun_q, overrun_d, rtsn_q, rtsn_d;

  logic        fall, strobe, cfg_acc, par_en, exp_par;
  logic [15:0] cnt_dec, eff_presc;
  logic [3:0]  size_eff;

  always_comb begin
    meta_d     = rxd;
    rxs_d      = meta_q;
    rxs_prev_d = rxs_q;
    // real_q[1] marks rxs_q as carrying a genuine rxd sample rather than the reset value;
    // a start is only accepted once the line has been seen high after reset.
    real_d     = {real_q[0], 1'b1};
    armed_d    = armed_q | (real_q[1] & rxs_q);
    fall       = armed_q & rxs_prev_q & ~rxs_q;

    cfg_acc    = axis.s_axis_config_tvalid && (state_q == S_IDLE);
    eff_presc  = cfg_acc ? axis.s_axis_config_tdata[15:0] : presc_q;
    size_eff   = (size_q == 4'd0) ? 4'd8 : size_q;
    par_en     = (par_mode_q != 3'd0) && (par_mode_q <= 3'd4);
    cnt_dec    = cnt_q - 16'd1;
    strobe     = (state_q != S_IDLE) && (cnt_dec == '0);

    case (par_mode_q)
      3'd1:    exp_par = run_par_q;
      3'd2:    exp_par = ~run_par_q;
      3'd3:    exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase

    state_d    = state_q;
    presc_d    = presc_q;
    par_mode_d = par_mode_q;
    size_d     = size_q;
    stop2_d    = stop2_q;
    cnt_d      = (state_q == S_IDLE) ? cnt_q : cnt_dec;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    run_par_d  = run_par_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    stop_idx_d = stop_idx_q;
    commit_d   = 1'b0;
    tdata_d    = tdata_q;
    tuser_d    = tuser_q;
    tvalid_d   = tvalid_q;
    overrun_d  = overrun_q;
    rtsn_d     = tvalid_q;

    if (cfg_acc) begin
      presc_d    = axis.s_axis_config_tdata[15:0];
      par_mode_d = axis.s_axis_config_tdata[18:16];
      size_d     = axis.s_axis_config_tdata[22:19];
      stop2_d    = axis.s_axis_config_tdata[23];
    end

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          cnt_d   = eff_presc >> 1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (strobe) begin
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            cnt_d      = presc_q;
            bit_d      = '0;
            shreg_d    = '0;
            run_par_d  = 1'b0;
            par_err_d  = 1'b0;
            frm_err_d  = 1'b0;
            stop_idx_d = 1'b0;
            state_d    = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (strobe) begin
          cnt_d          = presc_q;
          shreg_d[bit_q] = rxs_q;
          run_par_d      = run_par_q ^ rxs_q;
          bit_d          = bit_q + 4'd1;
          if (bit_q + 4'd1 == size_eff) state_d = par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (strobe) begin
          cnt_d     = presc_q;
          par_err_d = (rxs_q != exp_par);
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (strobe) begin
          if (!rxs_q) frm_err_d = 1'b1;
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
            cnt_d      = presc_q;
          end else begin
            commit_d = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A commit and an accept in the same cycle reload the register without a bubble.
    if (commit_q) begin
      if (!tvalid_q || axis.m_axis_tready) begin
        tdata_d   = shreg_q;
        tuser_d   = {overrun_q, frm_err_q, par_err_q};
        tvalid_d  = 1'b1;
        overrun_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (tvalid_q && axis.m_axis_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      meta_q     <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      real_q     <= '0;
      armed_q    <= 1'b0;
      presc_q    <= 16'(BAUD_PRESCALER);
      par_mode_q <= 3'(PARITY);
      size_q     <= 4'(BYTE_SIZE);
      stop2_q    <= (STOP_BITS != 0);
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      run_par_q  <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      stop_idx_q <= 1'b0;
      commit_q   <= 1'b0;
      tdata_q    <= '0;
      tuser_q    <= '0;
      tvalid_q   <= 1'b0;
      overrun_q  <= 1'b0;
      rtsn_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      meta_q     <= meta_d;
      rxs_q      <= rxs_d;
      rxs_prev_q <= rxs_prev_d;
      real_q     <= real_d;
      armed_q    <= armed_d;
      presc_q    <= presc_d;
      par_mode_q <= par_mode_d;
      size_q     <= size_d;
      stop2_q    <= stop2_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      run_par_q  <= run_par_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      stop_idx_q <= stop_idx_d;
      commit_q   <= commit_d;
      tdata_q    <= tdata_d;
      tuser_q    <= tuser_d;
      tvalid_q   <= tvalid_d;
      overrun_q  <= overrun_d;
      rtsn_q     <= rtsn_d;
    end
  end

  assign axis.s_axis_config_tready = (state_q == S_IDLE);
  assign axis.m_axis_tdata         = tdata_q;
  assign axis.m_axis_tuser         = tuser_q;
  assign axis.m_axis_tvalid        = tvalid_q;
  assign rtsn                      = rtsn_q;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer: frames are built from a line-level model,
// expected characters queued at send time and checked by an independent output monitor.
module tb_uart_rx_deframer;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic rxd = 1'b1;
  logic rtsn;

  uart_rx_deframer_if bus();

  uart_rx_deframer #(
    .BAUD_PRESCALER(12),
    .PARITY        (0),
    .BYTE_SIZE     (8),
    .STOP_BITS     (0)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .axis   (bus.master),
    .rxd    (rxd),
    .rtsn   (rtsn)
  );

  always #5 aclk = ~aclk;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [18:0] sb[$];

  int unsigned m_presc, m_par, m_size;
  bit m_stop2, hold, slot_full, ovr_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_defaults();
    m_presc = 12; m_par = 0; m_size = 8; m_stop2 = 1'b0;
    hold = 1'b0; slot_full = 1'b0; ovr_m = 1'b0;
  endtask

  task automatic set_ready(input bit r);
    bus.m_axis_tready = r;
    hold = !r;
    if (r) slot_full = 1'b0;
  endtask

  task automatic drive(input bit v);
    rxd = v;
    repeat (m_presc) @(posedge aclk);
    #1;
  endtask

  task automatic cfg(input int unsigned presc, input int unsigned par,
                     input int unsigned size, input bit stop2);
    int unsigned n;
    logic [15:0] p16;
    logic [2:0]  p3;
    logic [3:0]  s4;
    n = 0;
    while (!bus.s_axis_config_tready && n < 1000) begin
      @(posedge aclk); #1; n++;
    end
    if (!bus.s_axis_config_tready) begin
      tests++; fails++;
      $display("FAIL cfg_wait: got tready 0 expected 1 within 1000 cycles");
    end
    p16 = presc[15:0]; p3 = par[2:0]; s4 = size[3:0];
    bus.s_axis_config_tdata  = {stop2, s4, p3, p16};
    bus.s_axis_config_tvalid = 1'b1;
    @(posedge aclk); #1;
    bus.s_axis_config_tvalid = 1'b0;
    m_presc = presc; m_par = par; m_size = size; m_stop2 = stop2;
  endtask

  // Builds one character on the line from the configured format and queues what must come out.
  task automatic xfer(input logic [15:0] data_in, input bit flip_par, input bit bad_s0,
                      input bit bad_s1, input int unsigned gap_bits);
    int unsigned sz;
    logic [15:0] d, mask;
    bit pact, pbit, perr, ferr;
    sz   = (m_size == 0) ? 8 : m_size;
    mask = (16'd1 << sz) - 16'd1;
    d    = data_in & mask;
    pact = (m_par >= 1) && (m_par <= 4);
    case (m_par)
      1:       pbit = ^d;
      2:       pbit = ~^d;
      3:       pbit = 1'b1;
      default: pbit = 1'b0;
    endcase
    pbit = pbit ^ flip_par;
    perr = pact && flip_par;
    ferr = bad_s0 || (m_stop2 && bad_s1);
    if (hold && slot_full) begin
      ovr_m = 1'b1;
    end else begin
      sb.push_back({ovr_m, ferr, perr, d});
      ovr_m = 1'b0;
      if (hold) slot_full = 1'b1;
    end
    drive(1'b0);
    for (int unsigned i = 0; i < sz; i++) drive(d[i]);
    if (pact) drive(pbit);
    drive(!bad_s0);
    if (m_stop2) drive(!bad_s1);
    for (int unsigned i = 0; i < gap_bits; i++) drive(1'b1);
  endtask

  initial begin : monitor
    logic [18:0] exp;
    forever begin
      @(negedge aclk);
      if (aresetn && bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_char: got tdata 0x%0h tuser 0x%0h expected none",
                   bus.m_axis_tdata, bus.m_axis_tuser);
        end else begin
          exp = sb.pop_front();
          check("char", {13'd0, bus.m_axis_tuser, bus.m_axis_tdata}, {13'd0, exp});
        end
      end
    end
  end

  initial begin : stim
    int unsigned n;
    bit b0, b1;
    bus.s_axis_config_tdata  = '0;
    bus.s_axis_config_tvalid = 1'b0;
    bus.m_axis_tready        = 1'b1;
    model_defaults();

    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", bus.m_axis_tvalid, 0);
    check("rst_tdata", bus.m_axis_tdata, 0);
    check("rst_tuser", bus.m_axis_tuser, 0);
    check("rst_rtsn", rtsn, 1);
    check("rst_cfg_tready", bus.s_axis_config_tready, 1);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("rtsn_after_release", rtsn, 0);
    repeat (5) @(posedge aclk);
    #1;

    // 8N1 at prescaler 12, first character held so it can be inspected, then back-to-back.
    set_ready(1'b0);
    xfer(16'h00A5, 1'b0, 1'b0, 1'b0, 0);
    check("a5_tvalid", bus.m_axis_tvalid, 1);
    check("a5_tdata", bus.m_axis_tdata, 16'h00A5);
    check("a5_rtsn", rtsn, 1);
    set_ready(1'b1);
    xfer(16'h003C, 1'b0, 1'b0, 1'b0, 2);

    // Short low pulse is a false start.
    rxd = 1'b0;
    repeat (4) @(posedge aclk);
    #1;
    rxd = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("glitch_busy", bus.s_axis_config_tready, 0);
    repeat (12) @(posedge aclk);
    #1;
    check("glitch_idle", bus.s_axis_config_tready, 1);

    xfer(16'h0055, 1'b0, 1'b1, 1'b0, 1);
    xfer(16'h0012, 1'b0, 1'b0, 1'b0, 1);

    // Overrun: second character dropped while the first is held.
    set_ready(1'b0);
    xfer(16'h0011, 1'b0, 1'b0, 1'b0, 1);
    xfer(16'h0022, 1'b0, 1'b0, 1'b0, 1);
    check("ovr_tvalid", bus.m_axis_tvalid, 1);
    check("ovr_tdata", bus.m_axis_tdata, 16'h0011);
    check("ovr_rtsn", rtsn, 1);
    set_ready(1'b1);
    xfer(16'h0033, 1'b0, 1'b0, 1'b0, 1);

    // Prescaler 10, even parity, 8 bits, two stop bits.
    cfg(10, 1, 8, 1'b1);
    xfer(16'h0007, 1'b1, 1'b0, 1'b0, 1);
    xfer(16'h0007, 1'b0, 1'b0, 1'b0, 1);
    xfer(16'h00C8, 1'b0, 1'b1, 1'b0, 1);
    xfer(16'h0081, 1'b0, 1'b0, 1'b1, 1);

    // Reset mid-DATA with a held character pending.
    set_ready(1'b0);
    xfer(16'h00C3, 1'b0, 1'b0, 1'b0, 1);
    rxd = 1'b0;
    repeat (3 * m_presc) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    #1;
    check("midrst_tvalid", bus.m_axis_tvalid, 0);
    check("midrst_rtsn", rtsn, 1);
    sb.delete();
    model_defaults();
    bus.m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    repeat (30) @(posedge aclk);
    #1;
    check("post_rst_low_idle", bus.s_axis_config_tready, 1);
    rxd = 1'b1;
    repeat (5) @(posedge aclk);
    #1;
    xfer(16'h005A, 1'b0, 1'b0, 1'b0, 1);

    // Randomised formats and line errors.
    for (int unsigned f = 0; f < 40; f++) begin
      if (f % 5 == 0)
        cfg($urandom_range(16, 4), $urandom_range(7, 0), $urandom_range(15, 0), 1'($urandom_range(1, 0)));
      b0 = ($urandom_range(5, 0) == 0);
      b1 = ($urandom_range(5, 0) == 0);
      n  = $urandom_range(2, 0);
      if ((m_stop2 ? b1 : b0) && n == 0) n = 1;
      xfer(16'($urandom), ($urandom_range(3, 0) == 0), b0, b1, n);
    end

    n = 0;
    while ((sb.size() != 0 || bus.m_axis_tvalid) && n < 2000) begin
      @(posedge aclk); #1; n++;
    end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: got %0d characters outstanding expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
